// File: rtl/alu_md_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md_if
//  Purpose  : Bundles the operand, opcode and result signals of the EX-stage
//             ALU / multiply-divide unit into one interface.
//  Ports    : (interface signals)
//             A, B    - operands (rs, rt)
//             ALUctr  - combinational ALU opcode
//             md_op   - multiply/divide/move-to-HI/LO opcode
//             start   - qualifies md_op in this cycle
//             C       - combinational ALU result
//             busy    - multiply/divide in progress
//             hi, lo  - HI / LO registers
//             modport master : pipeline side (drives operands/opcodes)
//             modport slave  : alu_md side
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUctr;
    logic [2:0]       md_op;
    logic             start;
    logic [WIDTH-1:0] C;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output A, B, ALUctr, md_op, start,
        input  C, busy, hi, lo
    );

    modport slave (
        input  A, B, ALUctr, md_op, start,
        output C, busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
//  Module   : alu_md
//  Purpose  : Execute-stage ALU with a multi-cycle multiply/divide unit and
//             HI/LO registers. ALU ops are combinational; mult/multu/div/divu
//             hold busy high for a fixed MUL_LAT / DIV_LAT cycles and then
//             write HI/LO. mthi/mtlo write HI/LO in a single cycle.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             md_if  - alu_md_if.slave (A, B, ALUctr, md_op, start -> C,
//                      busy, hi, lo)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_md #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_md_if.slave  md_if
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;

    // ------------------------------------------------------------------
    // Combinational ALU (independent of the multiply/divide unit)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_c;

    always_comb begin
        alu_c = '0;
        case (md_if.ALUctr)
            4'd0: alu_c = md_if.A + md_if.B;
            4'd1: alu_c = md_if.A - md_if.B;
            4'd2: alu_c = md_if.A | md_if.B;
            4'd3: alu_c = {{(WIDTH-1){1'b0}}, (md_if.A == md_if.B)};
            4'd4: alu_c = md_if.A & md_if.B;
            4'd5: alu_c = md_if.A ^ md_if.B;
            4'd6: alu_c = {{(WIDTH-1){1'b0}}, ($signed(md_if.A) < $signed(md_if.B))};
            4'd7: alu_c = {{(WIDTH-1){1'b0}}, (md_if.A < md_if.B)};
            4'd8: alu_c = ~(md_if.A | md_if.B);
            4'd9: alu_c = md_if.B << 16;
            default: alu_c = '0;
        endcase
    end

    assign md_if.C = alu_c;

    // ------------------------------------------------------------------
    // Multiply / divide datapath, evaluated from the latched operands only
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                    $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed division goes through magnitudes so truncation toward zero and
    // a dividend-signed remainder fall out naturally. This also covers
    // -2^(WIDTH-1) / -1: the magnitude quotient 2^(WIDTH-1) re-reads as
    // -2^(WIDTH-1) with a zero remainder, exactly the required result.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, quo_m, rem_m, quo, rem;

    assign a_neg = (op_q == OP_DIV) && a_q[WIDTH-1];
    assign b_neg = (op_q == OP_DIV) && b_q[WIDTH-1];
    assign mag_a = a_neg ? (-a_q) : a_q;
    assign mag_b = b_neg ? (-b_q) : b_q;
    assign quo_m = mag_a / mag_b;
    assign rem_m = mag_a % mag_b;
    assign quo   = (a_neg ^ b_neg) ? (-quo_m) : quo_m;
    assign rem   = a_neg ? (-rem_m) : rem_m;

    logic [WIDTH-1:0] hi_res, lo_res;

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        case (op_q)
            OP_MULT:  {hi_res, lo_res} = prod_s;
            OP_MULTU: {hi_res, lo_res} = prod_u;
            default: begin
                // div / divu; a zero divisor returns all-ones and the dividend
                if (b_q == '0) begin
                    lo_res = '1;
                    hi_res = a_q;
                end else begin
                    lo_res = quo;
                    hi_res = rem;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control: accept / count down / write back
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (md_if.start) begin
                    case (md_if.md_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_W'(MUL_LAT);
                            a_d     = md_if.A;
                            b_d     = md_if.B;
                            op_d    = md_if.md_op;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_W'(DIV_LAT);
                            a_d     = md_if.A;
                            b_d     = md_if.B;
                            op_d    = md_if.md_op;
                        end
                        OP_MTHI: hi_d = md_if.A;
                        OP_MTLO: lo_d = md_if.A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // start is deliberately not examined here: requests during
                // execution are dropped, not queued.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    hi_d    = hi_res;
                    lo_d    = lo_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md_if.busy = (state_q == S_BUSY);
    assign md_if.hi   = hi_q;
    assign md_if.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_md
//  Purpose  : Self-checking bench for alu_md with a behavioural HI/LO and ALU
//             reference model and randomized operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_md;
    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(W)) bus ();

    alu_md #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md_if (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctr)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a | b;
            4'd3: r = (a == b) ? 32'd1 : 32'd0;
            4'd4: r = a & b;
            4'd5: r = a ^ b;
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            4'd8: r = ~(a | b);
            4'd9: r = {b[15:0], 16'h0000};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return ML;
        if (op == 3'd3 || op == 3'd4) return DL;
        return 0;
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd3: begin
                if (b == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
                else begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            end
            3'd4: begin
                if (b == 0) begin exp_lo = 32'hFFFF_FFFF; exp_hi = a; end
                else begin exp_lo = a / b; exp_hi = a % b; end
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one md request; must be entered while clk is low. Returns at the
    // negedge of the first cycle with busy=0 so a following call is back-to-back.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        int lat;
        logic [31:0] old_hi, old_lo, ra, rb;
        logic [3:0] ctr;
        lat    = lat_of(op);
        old_hi = exp_hi;
        old_lo = exp_lo;
        bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model_apply(op, a, b);
        for (int i = 0; i < lat; i++) begin
            ctr = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            bus.ALUctr = ctr; bus.A = ra; bus.B = rb;
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.hi !== old_hi || bus.lo !== old_lo) begin
                errors++;
                $display("FAIL %s busy cycle %0d: busy=%0b hi=%h lo=%h expected busy=1 hi=%h lo=%h",
                         name, i, bus.busy, bus.hi, bus.lo, old_hi, old_lo);
            end
            checks++;
            if (bus.C !== alu_ref(ctr, ra, rb)) begin
                errors++;
                $display("FAIL %s C during busy: ctr=%0d C=%h expected %h", name, ctr, bus.C, alu_ref(ctr, ra, rb));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL %s result: busy=%0b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                     name, bus.busy, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.md_op = 3'd0; bus.ALUctr = 4'd0; bus.A = '0; bus.B = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy=%0b hi=%h lo=%h expected 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL after reset: busy=%0b hi=%h lo=%h expected 0 0 0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_alu();
        logic [31:0] ra, rb;
        logic [3:0] ctr;
        bus.ALUctr = 4'd1; bus.A = 32'd3; bus.B = 32'd5; #1;
        checks++;
        if (bus.C !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub 3-5: C=%h expected fffffffe", bus.C); end
        bus.ALUctr = 4'd6; #1;
        checks++;
        if (bus.C !== 32'd1) begin errors++; $display("FAIL slt 3<5: C=%h expected 1", bus.C); end
        bus.ALUctr = 4'd7; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1; #1;
        checks++;
        if (bus.C !== 32'd0) begin errors++; $display("FAIL sltu ffffffff<1: C=%h expected 0", bus.C); end
        bus.ALUctr = 4'd6; #1;
        checks++;
        if (bus.C !== 32'd1) begin errors++; $display("FAIL slt -1<1: C=%h expected 1", bus.C); end
        for (int i = 0; i < 40; i++) begin
            ctr = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (i % 8 == 0) ? ra : $urandom;
            bus.ALUctr = ctr; bus.A = ra; bus.B = rb; #1;
            checks++;
            if (bus.C !== alu_ref(ctr, ra, rb)) begin
                errors++;
                $display("FAIL alu random ctr=%0d A=%h B=%h: C=%h expected %h", ctr, ra, rb, bus.C, alu_ref(ctr, ra, rb));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_md(3'd1, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult const: hi=%h lo=%h expected ffffffff ffffffeb", bus.hi, bus.lo);
        end
        run_md(3'd2, 32'hFFFF_FFFD, 32'd7, "multu");
        checks++;
        if (bus.hi !== 32'd6 || bus.lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL multu const: hi=%h lo=%h expected 00000006 ffffffeb", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        run_md(3'd3, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div const: hi=%h lo=%h expected ffffffff fffffffd", bus.hi, bus.lo);
        end
        run_md(3'd4, 32'd7, 32'd0, "divu 7/0");
        checks++;
        if (bus.hi !== 32'd7 || bus.lo !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL divu by zero: hi=%h lo=%h expected 00000007 ffffffff", bus.hi, bus.lo);
        end
        run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
            errors++; $display("FAIL div overflow: hi=%h lo=%h expected 00000000 80000000", bus.hi, bus.lo);
        end
        run_md(3'd3, 32'hFFFF_FF00, 32'd0, "div -256/0");
    endtask

    task automatic test_ignore();
        int n;
        bus.start = 1'b1; bus.md_op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model_apply(3'd3, 32'd100, 32'd7);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.md_op = 3'd6; bus.A = 32'd5;
            end else if (i == 4) begin
                bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd9; bus.B = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.busy === 1'b1) n++;
            else break;
        end
        bus.start = 1'b0;
        checks++;
        if (n != DL) begin errors++; $display("FAIL ignore busy length: cycles=%0d expected %0d", n, DL); end
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++; $display("FAIL ignore result: hi=%h lo=%h expected 00000002 0000000e", bus.hi, bus.lo);
        end
    endtask

    task automatic test_mthi();
        bus.start = 1'b1; bus.md_op = 3'd5; bus.A = 32'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        model_apply(3'd5, 32'h1234, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.hi !== 32'h1234 || bus.lo !== exp_lo) begin
                errors++;
                $display("FAIL mthi cycle %0d: busy=%0b hi=%h lo=%h expected busy=0 hi=00001234 lo=%h",
                         i, bus.busy, bus.hi, bus.lo, exp_lo);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_md(3'd5, $urandom | 32'd1, 32'd0, "mthi pre");
        run_md(3'd6, $urandom | 32'd1, 32'd0, "mtlo pre");
        bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd12345; bus.B = 32'd678;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL async reset mid-op: busy=%0b hi=%h lo=%h expected 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_md(3'd1, $urandom, $urandom, "mult after reset");
    endtask

    task automatic test_back_to_back();
        run_md(3'd4, $urandom, $urandom_range(1, 1000), "b2b divu");
        run_md(3'd1, $urandom, $urandom, "b2b mult");
        run_md(3'd6, $urandom, 32'd0, "b2b mtlo");
        run_md(3'd2, $urandom, $urandom, "b2b multu");
        run_md(3'd3, $urandom, $urandom, "b2b div");
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_md(op, a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mult();
        test_div();
        test_ignore();
        test_mthi();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
